// File: rtl/bsg_credit_pkg.sv
// Shared definitions for the multi-channel credit counter.
//   credit_width()  : bits needed to hold the values 0..n
//   credit_chan_s   : one channel's registered state (count + sticky flags)
//   credit_err_e    : encoding of a channel's error flags, used to name
//                     flag combinations when observing the counter
package bsg_credit_pkg;

  // Widest count any channel may instantiate. The channel keeps its count
  // in this width; bits above the configured width stay zero because the
  // count never exceeds max_credits_p.
  localparam int credit_cnt_w_max = 16;

  function automatic int credit_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef struct packed {
    logic [credit_cnt_w_max-1:0] count;
    logic                        overflow;
    logic                        underflow;
  } credit_chan_s;

  typedef enum logic [1:0] {
    err_none      = 2'b00,
    err_underflow = 2'b01,
    err_overflow  = 2'b10,
    err_both      = 2'b11
  } credit_err_e;

endpackage

// File: rtl/bsg_credit_counter_chan.sv
// One credit channel: holds a count, accepts a send (dec_i) when a credit
// is present, adds returned tokens (inc_cnt_i), saturates at max_credits_p
// and keeps sticky overflow/underflow flags.
// Ports:
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   infinite_credits_i   bypass: count held, dec/inc ignored, no flags
//   dec_i                consume one credit this cycle
//   inc_cnt_i            tokens returned this cycle (0..max_inc_p)
//   clear_err_i          clear sticky flags on the next edge
//   avail_o              channel may send this cycle
//   count_o              registered credit count
//   overflow_o           sticky: a return pushed the sum past max_credits_p
//   underflow_o          sticky: dec_i seen with no credit
//
// Handshake: avail_o is the "ready" for a send; a send is taken exactly when
// dec_i & avail_o in normal mode, and avail_o depends only on the registered
// count, so tokens returned this cycle cannot enable a send this cycle.
module bsg_credit_counter_chan
  import bsg_credit_pkg::*;
#(
  parameter  int max_credits_p  = 16,
  parameter  int init_credits_p = 16,
  parameter  int max_inc_p      = 4,
  localparam int cnt_width_lp   = credit_width(max_credits_p),
  localparam int inc_width_lp   = credit_width(max_inc_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    infinite_credits_i,
  input  logic                    dec_i,
  input  logic [inc_width_lp-1:0] inc_cnt_i,
  input  logic                    clear_err_i,
  output logic                    avail_o,
  output logic [cnt_width_lp-1:0] count_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  localparam int cw = credit_cnt_w_max;
  localparam int sw = credit_cnt_w_max + 1;

  localparam logic [cw-1:0] init_count = cw'(init_credits_p);
  localparam logic [cw-1:0] max_count  = cw'(max_credits_p);
  localparam logic [sw-1:0] max_sum    = sw'(max_credits_p);

  credit_chan_s st_q, st_d;

  logic          has_credit;
  logic          dec_ok;
  logic          unf_set;
  logic          ovf_set;
  logic [sw-1:0] sum;

  always_comb begin
    st_d       = st_q;
    has_credit = (st_q.count != '0);
    dec_ok     = dec_i & has_credit & ~infinite_credits_i;
    unf_set    = dec_i & ~has_credit & ~infinite_credits_i;
    // One extra bit so an overshoot past max_credits_p is visible; dec_ok
    // only subtracts from a nonzero count, so this never wraps below zero.
    sum        = {1'b0, st_q.count} + sw'(inc_cnt_i) - sw'(dec_ok);
    ovf_set    = ~infinite_credits_i & (sum > max_sum);
    if (!infinite_credits_i) begin
      st_d.count = ovf_set ? max_count : sum[cw-1:0];
    end
    // A new error in the same cycle as a clear wins over the clear.
    st_d.overflow  = ovf_set | (st_q.overflow & ~clear_err_i);
    st_d.underflow = unf_set | (st_q.underflow & ~clear_err_i);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      st_q <= '{count: init_count, overflow: 1'b0, underflow: 1'b0};
    end else begin
      st_q <= st_d;
    end
  end

  assign avail_o     = (st_q.count != '0) | infinite_credits_i;
  assign count_o     = st_q.count[cnt_width_lp-1:0];
  assign overflow_o  = st_q.overflow;
  assign underflow_o = st_q.underflow;

  // Returning more than max_inc_p tokens in one cycle is outside the
  // protocol; the counter's behaviour for it is not defined.
  inc_legal_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !infinite_credits_i |-> (32'(inc_cnt_i) <= max_inc_p));

endmodule

// File: rtl/bsg_credit_counter_multi.sv
// Multi-channel credit counter: els_p independent channels, each a
// bsg_credit_counter_chan. Packed per-channel vectors are sliced so that
// channel i occupies bit i / slice [i*width +: width] of every bus.
// Ports:
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   infinite_credits_i   [els_p]                 per-channel bypass
//   dec_i                [els_p]                 per-channel send request
//   inc_cnt_i            [els_p*inc_width_lp]    per-channel token return
//   clear_err_i          clear all sticky flags
//   credits_avail_o      [els_p]                 channel may send
//   credits_o            [els_p*cnt_width_lp]    registered counts
//   overflow_o           [els_p]                 sticky overflow flags
//   underflow_o          [els_p]                 sticky underflow flags
module bsg_credit_counter_multi
  import bsg_credit_pkg::*;
#(
  parameter  int els_p          = 4,
  parameter  int max_credits_p  = 16,
  parameter  int init_credits_p = 16,
  parameter  int max_inc_p      = 4,
  localparam int cnt_width_lp   = credit_width(max_credits_p),
  localparam int inc_width_lp   = credit_width(max_inc_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [els_p-1:0]              infinite_credits_i,
  input  logic [els_p-1:0]              dec_i,
  input  logic [els_p*inc_width_lp-1:0] inc_cnt_i,
  input  logic                          clear_err_i,
  output logic [els_p-1:0]              credits_avail_o,
  output logic [els_p*cnt_width_lp-1:0] credits_o,
  output logic [els_p-1:0]              overflow_o,
  output logic [els_p-1:0]              underflow_o
);

  for (genvar i = 0; i < els_p; i++) begin : g_chan
    bsg_credit_counter_chan #(
      .max_credits_p (max_credits_p),
      .init_credits_p(init_credits_p),
      .max_inc_p     (max_inc_p)
    ) u_chan (
      .clk_i             (clk_i),
      .reset_n_i         (reset_n_i),
      .infinite_credits_i(infinite_credits_i[i]),
      .dec_i             (dec_i[i]),
      .inc_cnt_i         (inc_cnt_i[i*inc_width_lp +: inc_width_lp]),
      .clear_err_i       (clear_err_i),
      .avail_o           (credits_avail_o[i]),
      .count_o           (credits_o[i*cnt_width_lp +: cnt_width_lp]),
      .overflow_o        (overflow_o[i]),
      .underflow_o       (underflow_o[i])
    );
  end

endmodule

// File: tb/tb_bsg_credit_counter_multi.sv
// Bench for bsg_credit_counter_multi with default parameters
// (4 channels, 16 credits, init 16, up to 4 tokens per return).
module tb_bsg_credit_counter_multi;
  import bsg_credit_pkg::*;

  localparam int els = 4;
  localparam int cw  = 5;
  localparam int iw  = 3;

  logic              clk;
  logic              reset_n;
  logic [els-1:0]    inf;
  logic [els-1:0]    dec;
  logic [els*iw-1:0] inc_cnt;
  logic              clear_err;
  logic [els-1:0]    avail;
  logic [els*cw-1:0] credits;
  logic [els-1:0]    ovf;
  logic [els-1:0]    unf;

  bsg_credit_counter_multi dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .infinite_credits_i(inf),
    .dec_i             (dec),
    .inc_cnt_i         (inc_cnt),
    .clear_err_i       (clear_err),
    .credits_avail_o   (avail),
    .credits_o         (credits),
    .overflow_o        (ovf),
    .underflow_o       (unf)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int               n_checks = 0;
  int               n_pass   = 0;
  int               m_cnt[els];
  bit               m_ovf[els];
  bit               m_unf[els];
  logic [els*cw-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic credit_err_e err_of(input logic o, input logic u);
    return credit_err_e'({o, u});
  endfunction

  function automatic logic [els*cw-1:0] model_credits();
    logic [els*cw-1:0] v;
    for (int i = 0; i < els; i++) v[i*cw +: cw] = cw'(m_cnt[i]);
    return v;
  endfunction

  function automatic logic [els-1:0] model_avail();
    logic [els-1:0] v;
    for (int i = 0; i < els; i++) v[i] = (m_cnt[i] != 0) || inf[i];
    return v;
  endfunction

  function automatic logic [els-1:0] model_ovf();
    logic [els-1:0] v;
    for (int i = 0; i < els; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  function automatic logic [els-1:0] model_unf();
    logic [els-1:0] v;
    for (int i = 0; i < els; i++) v[i] = m_unf[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < els; i++) begin
      m_cnt[i] = 16;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  // Apply the current inputs to the model for one clock edge.
  task automatic model_update();
    for (int i = 0; i < els; i++) begin
      bit o_set, u_set;
      int s;
      o_set = 1'b0;
      u_set = 1'b0;
      if (!inf[i]) begin
        s = m_cnt[i] + int'(inc_cnt[i*iw +: iw]);
        if (dec[i]) begin
          if (m_cnt[i] == 0) u_set = 1'b1;
          else s = s - 1;
        end
        if (s > 16) begin
          m_cnt[i] = 16;
          o_set    = 1'b1;
        end else begin
          m_cnt[i] = s;
        end
      end
      m_ovf[i] = o_set || (m_ovf[i] && !clear_err);
      m_unf[i] = u_set || (m_unf[i] && !clear_err);
    end
    exp_q.push_back(model_credits());
  endtask

  task automatic check_model(input string tag);
    check({tag, ".credits"}, 32'(credits), 32'(exp_q.pop_front()));
    check({tag, ".avail"},   32'(avail),   32'(model_avail()));
    check({tag, ".ovf"},     32'(ovf),     32'(model_ovf()));
    check({tag, ".unf"},     32'(unf),     32'(model_unf()));
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    dec       = '0;
    inc_cnt   = '0;
    clear_err = 1'b0;
  endtask

  task automatic set_inc(input int ch, input int val);
    inc_cnt[ch*iw +: iw] = iw'(val);
  endtask

  task automatic cycle(input string tag);
    model_update();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b1;
    inf     = '0;
    idle_inputs();
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    check("reset.credits", 32'(credits), 32'({4{5'd16}}));
    check("reset.avail",   32'(avail),   32'h0000000f);
    check("reset.ovf",     32'(ovf),     32'h0);
    check("reset.unf",     32'(unf),     32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Channel 0 drains to zero, then one more dec underflows.
    for (int k = 0; k < 16; k++) begin
      idle_inputs();
      dec[0] = 1'b1;
      cycle("ch0_drain");
      check("ch0_count", 32'(credits[4:0]), 32'(15 - k));
    end
    check("ch0_avail_zero", 32'(avail[0]), 32'h0);
    cycle("ch0_underflow");
    check("ch0_stuck_zero", 32'(credits[4:0]), 32'h0);
    check("ch0_unf",        32'(unf),          32'b0001);
    check("others_full",    32'(credits[19:5]), 32'({3{5'd16}}));

    // Channel 1: 14 + 4 - 1 = 17 saturates at 16 with overflow.
    idle_inputs();
    dec[1] = 1'b1;
    cycle("ch1_dec_a");
    cycle("ch1_dec_b");
    check("ch1_at14", 32'(credits[9:5]), 32'd14);
    set_inc(1, 4);
    cycle("ch1_sat");
    check("ch1_sat_count", 32'(credits[9:5]), 32'd16);
    check("ch1_ovf",       32'(ovf),          32'b0010);
    check("ch1_err",       32'(err_of(ovf[1], unf[1])), 32'(err_overflow));
    idle_inputs();
    clear_err = 1'b1;
    cycle("clear");
    check("clear_ovf", 32'(ovf), 32'h0);
    check("clear_unf", 32'(unf), 32'h0);
    set_inc(1, 1);
    cycle("clear_vs_set");
    check("set_wins", 32'(ovf), 32'b0010);

    // Channel 2: dec at zero is rejected while the return still lands.
    for (int k = 0; k < 16; k++) begin
      idle_inputs();
      dec[2] = 1'b1;
      cycle("ch2_drain");
    end
    check("ch2_zero",   32'(credits[14:10]), 32'h0);
    check("ch2_no_unf", 32'(unf[2]),         32'h0);
    set_inc(2, 3);
    cycle("ch2_inc_dec");
    check("ch2_count3", 32'(credits[14:10]), 32'd3);
    check("ch2_unf",    32'(unf),            32'b0100);
    idle_inputs();
    dec[2] = 1'b1;
    cycle("ch2_dec");
    check("ch2_count2", 32'(credits[14:10]), 32'd2);

    // Channel 3 to 5, then infinite mode holds the count.
    for (int k = 0; k < 11; k++) begin
      idle_inputs();
      dec[3] = 1'b1;
      cycle("ch3_drain");
    end
    check("ch3_at5", 32'(credits[19:15]), 32'd5);
    idle_inputs();
    inf = 4'b1001;
    #1;
    check("inf_avail_comb", 32'(avail), 32'b1111);
    for (int k = 0; k < 10; k++) begin
      dec = 4'b1001;
      set_inc(3, 2);
      cycle("ch3_inf");
      check("ch3_hold",  32'(credits[19:15]), 32'd5);
      check("ch3_avail", 32'(avail[3]),       32'h1);
    end
    check("inf_no_flags", 32'(unf), 32'b0100);
    idle_inputs();
    inf = '0;
    dec[3] = 1'b1;
    cycle("ch3_resume");
    check("ch3_count4", 32'(credits[19:15]), 32'd4);

    // Asynchronous reset between clock edges.
    idle_inputs();
    reset_n = 1'b0;
    #2;
    check("async.credits", 32'(credits), 32'({4{5'd16}}));
    check("async.avail",   32'(avail),   32'h0000000f);
    check("async.flags",   32'({ovf, unf}), 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Mixed traffic on all channels against the model.
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < els; i++) begin
        inf[i] = ($urandom_range(0, 7) == 0);
        dec[i] = 1'($urandom_range(0, 1));
        set_inc(i, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
      end
      clear_err = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
